hamming_secded_decoder: RTL
===========================

Name: hamming_secded_decoder

Overview:
Parametrised, pipelined single-error-correct / double-error-detect (SECDED) Hamming decoder. Accepts one extended Hamming codeword per cycle over a valid/ready handshake. Returns corrected data with error classification, and keeps saturating corrected/uncorrectable event counters. Sits downstream of the channel error-injection path, feeding the error-analysis statistics logic.

Parameters:
N, 8, data bits per codeword
R, 4, Hamming parity bits; elaboration must fail unless 2^R >= N+R+1
CNT_W, 16, width of each event counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  in_code valid
in_ready  output  1  decoder can accept in_code this cycle
in_code  input  N+R+1  bit i (1..N+R) = Hamming position i; bit 0 = overall parity
out_valid  output  1  out_* valid
out_ready  input  1  downstream accepts out_* this cycle
out_data  output  N  corrected data; out_data[0] = lowest non-power-of-2 position (3), ascending
out_corrected  output  1  single error found and corrected (incl. overall-parity bit)
out_uncorrectable  output  1  double or out-of-range error; data passed raw
out_syndrome  output  R  raw syndrome of this word
corr_count  output  CNT_W  saturating count of delivered corrected words
uncorr_count  output  CNT_W  saturating count of delivered uncorrectable words
cnt_clr  input  1  synchronous clear of both counters

Behaviour:
- Reset (async, immediate): all valids 0, out_data/out_syndrome/flags 0, both counters 0. in_ready is 1 after reset. A word in flight at reset is discarded.
- Syndrome bit k = XOR of in_code[j] for all j in 1..N+R with bit k of j set (includes parity position 2^k). P = XOR of all N+R+1 bits.
- Classification:
  - syn=0, P=0: clean.
  - syn=0, P=1: overall-parity bit error; data unchanged; corrected=1.
  - syn!=0, P=1, syn<=N+R: flip position syn; corrected=1. A flip at a power-of-2 position leaves data unchanged.
  - syn!=0, P=1, syn>N+R: uncorrectable; no flip.
  - syn!=0, P=0: double error; uncorrectable; no flip.
  - corrected and uncorrectable are never both 1.
- Pipeline, 2 register stages:
  - S1 registers the code, syndrome and P.
  - S2 registers the corrected/extracted data, flags and syndrome onto out_*.
  - Latency: 2 cycles from the in handshake to out_valid with out_ready held 1. Throughput: 1 word/cycle.
- Backpressure:
  - S2 holds while out_valid && !out_ready.
  - S1 advances when S2 is empty or draining.
  - in_ready = !S1_valid || S1 advancing (combinational, no bubble).
  - out_* stay stable while out_valid && !out_ready.
  - Words are never dropped, duplicated or reordered.
- Counters:
  - Increment only on the out handshake (out_valid && out_ready), so each word counts once.
  - Saturate at 2^CNT_W-1.
  - cnt_clr takes priority over a simultaneous increment; that word is not counted.

Test Plan:
- N=8,R=4; in_code=0x144E (data 0xA5), out_ready=1 -> out_valid 2 cycles later, out_data=0xA5, corrected=0, uncorrectable=0, syndrome=0, counters unchanged.
- in_code=0x140E (position 6 flipped) -> out_data=0xA5, corrected=1, syndrome=6, corr_count +1. Repeat with 0x144F (bit 0 flipped) -> 0xA5, corrected=1, syndrome=0.
- in_code=0x1466 (positions 3,5 flipped) -> uncorrectable=1, syndrome=6, out_data=0xA6 raw, uncorr_count +1. Also in_code=0x155C (positions 1,4,8 flipped) -> syndrome=13 > 12 -> uncorrectable=1, out_data=0xA5.
- Stream 8 back-to-back words; hold out_ready=0 for 3 cycles mid-stream -> in_ready drops after the pipe fills, out_* hold stable, all 8 words emerge in order, none lost or duplicated.
- CNT_W=3; send 9 single-error words -> corr_count saturates at 7. Assert cnt_clr in the same cycle as a corrected handshake -> count 0, not 1.
- Assert rst mid-stream with 2 words in flight -> out_valid=0 and counters 0 immediately. After release in_ready=1 and the next word decodes normally.

Source files
------------

// File: rtl/hamming_secded_decoder.sv
// Two-stage SECDED Hamming decoder with saturating corrected/uncorrectable event counters.
// Latency 2 cycles, 1 word/cycle; S2 holds under out backpressure, S1 and in_ready follow without a bubble.
module hamming_secded_decoder #(
    parameter int N     = 8,
    parameter int R     = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N+R:0]     in_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_data,
    output logic             out_corrected,
    output logic             out_uncorrectable,
    output logic [R-1:0]     out_syndrome,
    output logic [CNT_W-1:0] corr_count,
    output logic [CNT_W-1:0] uncorr_count,
    input  logic             cnt_clr
);
    localparam int M = N + R;

    generate
        if ((2 ** R) < (M + 1)) begin : g_bad_params
            $fatal(1, "hamming_secded_decoder: 2^R must be >= N+R+1");
        end
    endgenerate

    // Position of the i-th data bit: i-th non-power-of-2 position, ascending.
    function automatic int data_pos(input int i);
        int cnt;
        int pos;
        cnt = 0;
        pos = 0;
        for (int j = 1; j <= M; j++) begin
            if ((j & (j - 1)) != 0) begin
                if (cnt == i) pos = j;
                cnt++;
            end
        end
        return pos;
    endfunction

    logic [R-1:0] syn_c;
    logic         par_c;

    always_comb begin
        syn_c = '0;
        for (int k = 0; k < R; k++) begin
            for (int j = 1; j <= M; j++) begin
                if (((j >> k) & 1) == 1) syn_c[k] = syn_c[k] ^ in_code[j];
            end
        end
        par_c = ^in_code;
    end

    logic         s1_valid;
    logic [M:0]   s1_code;
    logic [R-1:0] s1_syn;
    logic         s1_par;
    logic         s2_adv;

    assign s2_adv   = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_adv;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_code  <= '0;
            s1_syn   <= '0;
            s1_par   <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_code <= in_code;
                s1_syn  <= syn_c;
                s1_par  <= par_c;
            end
        end
    end

    logic         syn_nz;
    logic         in_range;
    logic         flip;
    logic         corr_c;
    logic         uncorr_c;
    logic [M:0]   flip_mask;
    logic [M:0]   fixed_code;
    logic [N-1:0] data_c;

    always_comb begin
        syn_nz    = |s1_syn;
        in_range  = (int'(s1_syn) <= M);
        flip      = s1_par && syn_nz && in_range;
        // Odd parity with zero syndrome is the overall-parity bit itself: counted, nothing to flip.
        corr_c    = s1_par && (!syn_nz || in_range);
        uncorr_c  = syn_nz && (!s1_par || !in_range);
        flip_mask = '0;
        flip_mask[0] = flip;
        fixed_code = s1_code ^ (flip_mask << s1_syn);
        data_c = '0;
        for (int i = 0; i < N; i++) begin
            data_c[i] = fixed_code[data_pos(i)];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid         <= 1'b0;
            out_data          <= '0;
            out_corrected     <= 1'b0;
            out_uncorrectable <= 1'b0;
            out_syndrome      <= '0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data          <= data_c;
                out_corrected     <= corr_c;
                out_uncorrectable <= uncorr_c;
                out_syndrome      <= s1_syn;
            end
        end
    end

    logic out_hs;
    assign out_hs = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            corr_count   <= '0;
            uncorr_count <= '0;
        end else if (cnt_clr) begin
            corr_count   <= '0;
            uncorr_count <= '0;
        end else if (out_hs) begin
            if (out_corrected && (corr_count != '1))
                corr_count <= corr_count + CNT_W'(1);
            if (out_uncorrectable && (uncorr_count != '1))
                uncorr_count <= uncorr_count + CNT_W'(1);
        end
    end

endmodule
